// File: rtl/dualtimer_clken_ctrl_if.sv
// rtl/dualtimer_clken_ctrl_if.sv - APB signal bundle for the dual-timer clock-enable scheduler
//
// Purpose: groups the APB slave signals of dualtimer_clken_ctrl.
// Signals:
//   PSEL, PENABLE, PWRITE  - APB select, access phase and direction (master -> slave)
//   PADDR[11:0]            - byte address; bits [1:0] are ignored by the slave
//   PWDATA[31:0]           - write data
//   PRDATA[31:0]           - read data (slave -> master)
//   PREADY, PSLVERR        - transfer completion and error response (slave -> master)

interface dualtimer_clken_ctrl_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/dualtimer_clken_ctrl.sv
// rtl/dualtimer_clken_ctrl.sv - APB-programmable two-channel clock-enable pulse generator
//
// Purpose: divides PCLK by two independent programmable divisors and emits one
// registered, single-cycle qualifier pulse per channel every DIVn+1 cycles.
// Ports:
//   PCLK              - sole clock, rising edge
//   PRESETn           - asynchronous active-low reset
//   apb               - APB slave (dualtimer_clken_ctrl_if.slave), zero wait states
//   dualtimer_clken1  - channel-1 clock-enable pulse (flop output)
//   dualtimer_clken2  - channel-2 clock-enable pulse (flop output)
// Register map (byte offsets):
//   0x00 CTRL  RW  bit0 EN1, bit1 EN2, bit2 RESTART (self-clearing, reads 0)
//   0x04 DIV1  RW  0x08 DIV2 RW
//   0x0C CNT1  RO  0x10 CNT2 RO  0x14 STATUS RO {clken2, clken1}

module dualtimer_clken_ctrl #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  dualtimer_clken_ctrl_if.slave apb,
  output logic                  dualtimer_clken1,
  output logic                  dualtimer_clken2
);

  localparam logic [9:0] W_CTRL   = 10'd0;
  localparam logic [9:0] W_DIV1   = 10'd1;
  localparam logic [9:0] W_DIV2   = 10'd2;
  localparam logic [9:0] W_CNT1   = 10'd3;
  localparam logic [9:0] W_CNT2   = 10'd4;
  localparam logic [9:0] W_STATUS = 10'd5;

  logic [1:0]           r_en;
  logic [DIV_WIDTH-1:0] r_div [2];
  logic [DIV_WIDTH-1:0] r_cnt [2];
  logic [1:0]           r_clken;
  logic                 r_restart;

  logic [9:0]  w_word;
  logic        w_unmapped;
  logic        w_ro;
  logic        w_access;
  logic        w_err;
  logic        w_wr;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_word     = apb.PADDR[11:2];
  assign w_unmapped = (w_word > W_STATUS);
  assign w_ro       = (w_word >= W_CNT1) && !w_unmapped;
  assign w_access   = apb.PSEL && apb.PENABLE;
  assign w_err      = w_access && (w_unmapped || (apb.PWRITE && w_ro));
  // Erroring writes are squashed here so they never reach register state.
  assign w_wr       = w_access && apb.PWRITE && !w_err;
  assign w_unused   = ^{apb.PADDR[1:0], apb.PWDATA};

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_en      <= 2'b00;
      r_clken   <= 2'b00;
      r_restart <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_div[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      // RESTART is captured on the committing edge and acts one edge later.
      r_restart <= w_wr && (w_word == W_CTRL) && apb.PWDATA[2];

      if (w_wr) begin
        case (w_word)
          W_CTRL:  r_en     <= apb.PWDATA[1:0];
          W_DIV1:  r_div[0] <= apb.PWDATA[DIV_WIDTH-1:0];
          W_DIV2:  r_div[1] <= apb.PWDATA[DIV_WIDTH-1:0];
          default: ;
        endcase
      end

      // Reload always reads the registered divisor, so a divisor written
      // mid-period only takes effect at the next terminal count. RESTART
      // takes priority over a terminal count and suppresses that pulse.
      for (int i = 0; i < 2; i++) begin
        if (r_restart || !r_en[i]) begin
          r_cnt[i]   <= r_div[i];
          r_clken[i] <= 1'b0;
        end else if (r_cnt[i] == '0) begin
          r_cnt[i]   <= r_div[i];
          r_clken[i] <= 1'b1;
        end else begin
          r_cnt[i]   <= r_cnt[i] - 1'b1;
          r_clken[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (apb.PSEL && !apb.PWRITE) begin
      case (w_word)
        W_CTRL:   w_rdata = {30'b0, r_en};
        W_DIV1:   w_rdata = 32'(r_div[0]);
        W_DIV2:   w_rdata = 32'(r_div[1]);
        W_CNT1:   w_rdata = 32'(r_cnt[0]);
        W_CNT2:   w_rdata = 32'(r_cnt[1]);
        W_STATUS: w_rdata = {30'b0, r_clken};
        default:  w_rdata = '0;
      endcase
    end
  end

  assign apb.PRDATA   = w_rdata;
  assign apb.PREADY   = 1'b1;
  assign apb.PSLVERR  = w_err;
  assign dualtimer_clken1 = r_clken[0];
  assign dualtimer_clken2 = r_clken[1];

endmodule

// File: tb/tb_dualtimer_clken_ctrl.sv
// tb/tb_dualtimer_clken_ctrl.sv - scoreboard testbench for dualtimer_clken_ctrl

module tb_dualtimer_clken_ctrl;
  logic PCLK    = 1'b0;
  logic PRESETn = 1'b1;
  logic dualtimer_clken1;
  logic dualtimer_clken2;

  dualtimer_clken_ctrl_if apb_if();

  dualtimer_clken_ctrl #(.DIV_WIDTH(16)) dut (
    .PCLK             (PCLK),
    .PRESETn          (PRESETn),
    .apb              (apb_if),
    .dualtimer_clken1 (dualtimer_clken1),
    .dualtimer_clken2 (dualtimer_clken2)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic mon1 = 1'b0;
  logic mon2 = 1'b0;
  int exp_p1[$];
  int exp_p2[$];
  logic [32:0] exp_apb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // APB response monitor: one expected {PSLVERR, PRDATA} per access phase.
  always @(negedge PCLK) begin : apb_mon
    logic [32:0] e;
    if (PRESETn && apb_if.PSEL && apb_if.PENABLE) begin
      if (exp_apb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL apb_unexpected: got access 0x%0h required none", apb_if.PADDR);
      end else begin
        e = exp_apb.pop_front();
        chk($sformatf("prdata@%0h", apb_if.PADDR), apb_if.PRDATA, e[31:0]);
        chk($sformatf("pslverr@%0h", apb_if.PADDR), {31'b0, apb_if.PSLVERR}, {31'b0, e[32]});
        chk("pready", {31'b0, apb_if.PREADY}, 32'd1);
      end
    end
  end

  // Pulse monitors: each high cycle must match the head expected cycle.
  always @(negedge PCLK) begin
    if (mon1) begin
      if (exp_p1.size() != 0 && exp_p1[0] < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL clken1_missing: got 0 required 1 at cycle %0d", exp_p1[0]);
        void'(exp_p1.pop_front());
      end
      if (dualtimer_clken1) begin
        n_checks++;
        if (exp_p1.size() != 0 && exp_p1[0] == cyc) void'(exp_p1.pop_front());
        else begin
          n_fail++;
          $display("FAIL clken1_unexpected: got 1 required 0 at cycle %0d", cyc);
        end
      end
    end
  end

  always @(negedge PCLK) begin
    if (mon2) begin
      if (exp_p2.size() != 0 && exp_p2[0] < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL clken2_missing: got 0 required 1 at cycle %0d", exp_p2[0]);
        void'(exp_p2.pop_front());
      end
      if (dualtimer_clken2) begin
        n_checks++;
        if (exp_p2.size() != 0 && exp_p2[0] == cyc) void'(exp_p2.pop_front());
        else begin
          n_fail++;
          $display("FAIL clken2_unexpected: got 1 required 0 at cycle %0d", cyc);
        end
      end
    end
  end

  // Setup phase after the first edge, access after the second, commit on the third.
  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, output int t);
    @(posedge PCLK); #1;
    apb_if.PSEL    = 1'b1;
    apb_if.PENABLE = 1'b0;
    apb_if.PWRITE  = wr;
    apb_if.PADDR   = addr;
    apb_if.PWDATA  = wdata;
    exp_apb.push_back({exp_err, exp_rd});
    @(posedge PCLK); #1;
    apb_if.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    t = cyc;
    apb_if.PSEL    = 1'b0;
    apb_if.PENABLE = 1'b0;
    apb_if.PWRITE  = 1'b0;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data, input logic err, output int t);
    apb_xfer(1'b1, addr, data, 32'd0, err, t);
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp_rd, input logic err);
    int t;
    apb_xfer(1'b0, addr, 32'd0, exp_rd, err, t);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge PCLK); #1;
    end
  endtask

  task automatic drain(input string tag);
    chk({tag, "_p1_left"}, exp_p1.size(), 32'd0);
    chk({tag, "_p2_left"}, exp_p2.size(), 32'd0);
    exp_p1.delete();
    exp_p2.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tt, tr, rc;
    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
    apb_if.PADDR = '0;  apb_if.PWDATA = '0;

    // Reset defaults
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_clken1", {31'b0, dualtimer_clken1}, 32'd0);
    chk("rst_clken2", {31'b0, dualtimer_clken2}, 32'd0);
    chk("rst_pready", {31'b0, apb_if.PREADY}, 32'd1);
    chk("rst_pslverr", {31'b0, apb_if.PSLVERR}, 32'd0);
    chk("rst_prdata", apb_if.PRDATA, 32'd0);
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    for (int a = 0; a < 6; a++) rd(12'(a * 4), 32'd0, 1'b0);

    // Divide: DIV1=3 pulses every 4, DIV2=0 constant high
    wr(12'h004, 32'd3, 1'b0, t);
    wr(12'h008, 32'd0, 1'b0, t);
    mon1 = 1'b1; mon2 = 1'b1;
    wr(12'h000, 32'd3, 1'b0, t);
    for (int k = 1; k <= 4; k++) exp_p1.push_back(t + 4 * k);
    for (int k = 1; k <= 16; k++) exp_p2.push_back(t + k);
    wait_cyc(t + 17);
    mon1 = 1'b0; mon2 = 1'b0;
    drain("divide");
    wr(12'h000, 32'd0, 1'b0, t);

    // On-the-fly divisor: 4 -> 1 written mid-period
    wr(12'h004, 32'd4, 1'b0, t);
    mon1 = 1'b1;
    wr(12'h000, 32'd1, 1'b0, tt);
    exp_p1.push_back(tt + 5);  exp_p1.push_back(tt + 10);
    exp_p1.push_back(tt + 12); exp_p1.push_back(tt + 14);
    exp_p1.push_back(tt + 16);
    rd(12'h00C, 32'd2, 1'b0);
    wr(12'h004, 32'd1, 1'b0, t);
    rd(12'h00C, 32'd1, 1'b0);
    rd(12'h004, 32'd1, 1'b0);
    wait_cyc(tt + 17);
    mon1 = 1'b0;
    drain("onfly");
    wr(12'h000, 32'd0, 1'b0, t);

    // Restart alignment: channels started out of phase
    wr(12'h004, 32'd2, 1'b0, t);
    wr(12'h008, 32'd5, 1'b0, t);
    wr(12'h000, 32'd1, 1'b0, t);
    wait_cyc(t + 4);
    wr(12'h000, 32'd3, 1'b0, t);
    wr(12'h000, 32'd7, 1'b0, tr);
    wait_cyc(tr + 1);
    mon1 = 1'b1; mon2 = 1'b1;
    for (int k = 1; k <= 4; k++) exp_p1.push_back(tr + 1 + 3 * k);
    exp_p2.push_back(tr + 7); exp_p2.push_back(tr + 13);
    wait_cyc(tr + 14);
    mon1 = 1'b0; mon2 = 1'b0;
    drain("align");

    // Restart vs terminal count: RESTART acts on the edge where cnt1 == 0
    wait_cyc(tr + 15);
    wr(12'h000, 32'd7, 1'b0, rc);
    mon1 = 1'b1; mon2 = 1'b1;
    exp_p1.push_back(rc + 4); exp_p1.push_back(rc + 7);
    exp_p2.push_back(rc + 7);
    wait_cyc(rc + 8);
    mon1 = 1'b0; mon2 = 1'b0;
    drain("rst_vs_tc");
    rd(12'h000, 32'd3, 1'b0);
    wr(12'h000, 32'd0, 1'b0, t);

    // Error responses
    wr(12'h00C, 32'h55, 1'b1, t);
    rd(12'h018, 32'd0, 1'b1);
    wr(12'h100, 32'd3, 1'b1, t);
    rd(12'h00C, 32'd2, 1'b0);
    wr(12'h004, 32'hABCD0002, 1'b0, t);
    rd(12'h004, 32'd2, 1'b0);
    wr(12'h014, 32'd3, 1'b1, t);
    rd(12'h000, 32'd0, 1'b0);
    rd(12'hFFC, 32'd0, 1'b1);

    // STATUS while running, then asynchronous reset mid-run
    wr(12'h008, 32'd0, 1'b0, t);
    wr(12'h000, 32'd2, 1'b0, t);
    rd(12'h014, 32'd2, 1'b0);
    rd(12'h010, 32'd0, 1'b0);
    @(posedge PCLK); #1;
    chk("clken2_before_reset", {31'b0, dualtimer_clken2}, 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    chk("midrst_clken1", {31'b0, dualtimer_clken1}, 32'd0);
    chk("midrst_clken2", {31'b0, dualtimer_clken2}, 32'd0);
    chk("midrst_pready", {31'b0, apb_if.PREADY}, 32'd1);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    for (int a = 0; a < 6; a++) rd(12'(a * 4), 32'd0, 1'b0);
    repeat (3) @(posedge PCLK);
    #1;
    chk("post_rst_clken2", {31'b0, dualtimer_clken2}, 32'd0);

    chk("apb_left", exp_apb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dualtimer_clken_ctrl.md
# dualtimer_clken_ctrl

APB-programmable clock-enable scheduler for the dual timer. It generates the `dualtimer_clken1` and `dualtimer_clken2` qualifier pulses from `PCLK` using two independent programmable dividers. It sits between the APB bus and the dual timer's TIMCLKEN inputs, and replaces bench-driven clock enables in the subsystem.

## Interface
- `DIV_WIDTH`, 16, width of each divisor and counter (2..32)
- `PCLK` in 1: sole clock; all state updates on the rising edge
- `PRESETn` in 1: asynchronous, active-low reset
- `PSEL` in 1: APB select
- `PENABLE` in 1: APB access phase
- `PWRITE` in 1: 1 = write
- `PADDR` in 12: byte address; bits [1:0] ignored
- `PWDATA` in 32: write data
- `PRDATA` out 32: read data
- `PREADY` out 1: tied 1; zero wait states
- `PSLVERR` out 1: error response
- `dualtimer_clken1` out 1: channel-1 clock-enable pulse, registered
- `dualtimer_clken2` out 1: channel-2 clock-enable pulse, registered

## Operation
- Register map (offsets):
  - 0x00 CTRL RW: bit0 EN1, bit1 EN2, bit2 RESTART (write-1 pulse, reads 0), others RAZ/WI.
  - 0x04 DIV1 RW: [DIV_WIDTH-1:0].
  - 0x08 DIV2 RW: [DIV_WIDTH-1:0].
  - 0x0C CNT1 RO, 0x10 CNT2 RO: live counter values.
  - 0x14 STATUS RO: bit0 = current clken1, bit1 = current clken2.
- APB transfers:
  - A write commits on the rising edge where PSEL & PENABLE & PWRITE.
  - Read data is combinational from the current register state while PSEL & !PWRITE, else 0.
- PSLVERR:
  - Set to 1 during the access phase for an unmapped offset (≥0x18), or for a write to a read-only register (0x0C–0x14); 0 otherwise.
  - Erroring writes have no effect.
  - Erroring reads return 0.
- Per-channel counter n (identical logic, independent):
  - ENn = 0: cntn ← DIVn, clkenn ← 0.
  - ENn = 1, cntn == 0: cntn ← DIVn, clkenn ← 1.
  - ENn = 1, cntn ≠ 0: cntn ← cntn − 1, clkenn ← 0.
  - Result: one 1-cycle pulse every DIVn+1 PCLK cycles.
  - DIVn = 0 holds clkenn continuously high while enabled.
- DIVn write while enabled:
  - Does not disturb cntn.
  - The new value is used at the next reload (current period completes with the old divisor).
- RESTART:
  - On the edge after the committing write, cnt1 ← DIV1, cnt2 ← DIV2, clken1/2 ← 0, regardless of EN.
  - Use it to phase-align the channels.
- Simultaneous events:
  - RESTART beats a terminal count: no pulse that cycle.
  - A CTRL write setting EN and RESTART together behaves as enable-from-reload.
- Counter arithmetic is unsigned DIV_WIDTH bits. Decrement never goes below 0, so there is no wrap.

## Timing
- Reset (async assert, sync-safe deassert handled upstream): EN1 = EN2 = 0, DIV1 = DIV2 = 0, cnt1 = cnt2 = 0, clken1 = clken2 = 0, PSLVERR = 0, PRDATA = 0, PREADY = 1.
- Reset asserted mid-period aborts immediately. Outputs drop asynchronously.
- Enable latency:
  - ENn is written at edge T.
  - First clkenn high during the cycle after edge T+DIVn+1, then every DIVn+1 cycles.
- Disable: EN cleared at edge T means clkenn is 0 from edge T+1 onward. A pulse already high completes its single cycle.
- Register readback: the value written at edge T is readable in an access beginning at T+1. CNTn reflects the state after the most recent edge.
- Outputs are driven only from flops; there is no combinational path from APB to clken.

## Test plan
- Reset/defaults: assert PRESETn = 0 mid-run → clken1/2 = 0 immediately. All registers read 0. PREADY = 1.
- Divide: DIV1 = 3, EN1 = 1 at edge T → clken1 high for one cycle at edges T+4, T+8, T+12… DIV2 = 0, EN2 = 1 → clken2 constantly high from T+1.
- On-the-fly divisor: DIV1 = 4 running, write DIV1 = 1 mid-period → the current 5-cycle period finishes, then pulses every 2 cycles. CNT1 reads a decreasing 4..0 before the change.
- Restart alignment: DIV1 = 2, DIV2 = 5 running out of phase, write RESTART → both counters reload on the next edge. First coincident pulse arrives 6 cycles later, then every 6 cycles (LCM).
- Restart vs terminal count: issue RESTART on the cycle cnt1 == 0 → no clken1 pulse that cycle. Next pulse arrives DIV1+1 cycles later.
- Errors: write 0x0C, read 0x18, write 0x100 → PSLVERR = 1 in each access phase. CNT1 is unchanged and read data is 0. A valid access to 0x04 → PSLVERR = 0.
